// File: rtl/r200_dmem_resp_if.sv
// r200_dmem_resp_if
//   Request/response bus between a data-memory initiator and the
//   r200_dmem_resp responder.
//   Request channel  : req_valid/req_ready handshake carrying req_we,
//                      req_addr (byte address), req_wdata and req_be.
//   Response channel : rsp_valid/rsp_ready handshake carrying rsp_rdata
//                      and rsp_err.
//   Modports: master = initiator side, slave = responder side.
interface r200_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/r200_dmem_resp.sv
// r200_dmem_resp
//   Single-outstanding data-memory responder with DEPTH 32-bit words and a
//   fixed LATENCY wait-state delay between request acceptance and response.
//   Stores commit to storage on the acceptance edge (byte-enabled); loads
//   read storage on the edge that enters the response state. Misaligned or
//   out-of-range addresses fault: no storage update, rsp_err = 1, data 0.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (storage is not cleared)
//     bus  - r200_dmem_resp_if.slave request/response channels
module r200_dmem_resp #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  r200_dmem_resp_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic          we_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          rsp_err_q;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          req_fault;
  logic [AW-1:0] req_idx;
  logic          store_commit;
  logic          enter_resp;
  logic [AW-1:0] rd_idx;
  logic          rd_load;
  logic          rd_err;

  assign req_idx   = bus.req_addr[AW+1:2];
  assign req_fault = (bus.req_addr[1:0] != 2'b00) ||
                     (bus.req_addr[31:2] >= 30'(DEPTH));

  // Reset gates ready combinationally so nothing is accepted on a reset edge.
  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign store_commit  = accept && bus.req_we && !req_fault;

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // With LATENCY = 0 the acceptance edge is also the edge entering RESP, so
  // the read address and load/fault qualifiers come straight from the bus in
  // IDLE and from the latched request otherwise.
  assign enter_resp = ((state_q == ST_IDLE) && accept && (LATENCY == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign rd_idx     = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign rd_err     = (state_q == ST_IDLE) ? req_fault : err_q;
  assign rd_load    = (state_q == ST_IDLE) ? (!bus.req_we && !req_fault)
                                           : (!we_q && !err_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= req_idx;
        we_q  <= bus.req_we;
        err_q <= req_fault;
      end
      // Response fields only change when entering RESP, which keeps them
      // stable for the whole time the initiator applies backpressure.
      if (enter_resp) begin
        rdata_q   <= rd_load ? mem[rd_idx] : 32'd0;
        rsp_err_q <= rd_err;
      end
    end
  end

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_be[b]) begin
          mem[req_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_r200_dmem_resp.sv
module tb_r200_dmem_resp;

  localparam int DEPTH_A = 1024;
  localparam int LAT_A   = 2;
  localparam int DEPTH_B = 16;
  localparam int LAT_B   = 0;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  // shared request fields, per-DUT valid
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        t_we = 1'b0;
  logic [31:0] t_addr = 32'd0;
  logic [31:0] t_wdata = 32'd0;
  logic [3:0]  t_be = 4'd0;
  logic        t_rsp_ready = 1'b0;
  int          sel = 0;

  r200_dmem_resp_if bus_a ();
  r200_dmem_resp_if bus_b ();

  assign bus_a.req_valid = valid_a;
  assign bus_a.req_we    = t_we;
  assign bus_a.req_addr  = t_addr;
  assign bus_a.req_wdata = t_wdata;
  assign bus_a.req_be    = t_be;
  assign bus_a.rsp_ready = t_rsp_ready;
  assign bus_b.req_valid = valid_b;
  assign bus_b.req_we    = t_we;
  assign bus_b.req_addr  = t_addr;
  assign bus_b.req_wdata = t_wdata;
  assign bus_b.req_be    = t_be;
  assign bus_b.rsp_ready = t_rsp_ready;

  r200_dmem_resp #(.DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  r200_dmem_resp #(.DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  assign o_req_ready = (sel != 0) ? bus_b.req_ready : bus_a.req_ready;
  assign o_rsp_valid = (sel != 0) ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign o_rsp_rdata = (sel != 0) ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign o_rsp_err   = (sel != 0) ? bus_b.rsp_err   : bus_a.rsp_err;

  int errors = 0;
  int checks = 0;

  // Reference storage: word index -> value, only for fully known words.
  logic [31:0] model_a [int];
  logic [31:0] model_b [int];

  logic [31:0] last_rdata;
  logic        last_err;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One full transaction; starts and ends 1 time unit after a rising edge.
  task automatic txn(input int s, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold);
    int lat, depth, n, idx;
    bit exp_err, known;
    logic [31:0] exp_data, held_d, oldw;
    logic held_e;
    sel = s;
    lat = (s != 0) ? LAT_B : LAT_A;
    depth = (s != 0) ? DEPTH_B : DEPTH_A;
    exp_err = (addr % 4 != 0) || ((addr / 4) >= depth);
    idx = int'(addr / 4);
    known = 1'b1;
    exp_data = 32'd0;
    if (!we && !exp_err) begin
      if (s != 0 && model_b.exists(idx)) exp_data = model_b[idx];
      else if (s == 0 && model_a.exists(idx)) exp_data = model_a[idx];
      else known = 1'b0;
    end
    t_we = we; t_addr = addr; t_wdata = wdata; t_be = be;
    t_rsp_ready = (hold == 0);
    if (s != 0) valid_b = 1'b1; else valid_a = 1'b1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", o_req_ready);
    end
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    // garbage on ignored inputs while busy
    t_we = 1'($urandom); t_addr = $urandom; t_wdata = $urandom; t_be = 4'($urandom);
    if (we && !exp_err) begin
      if (s != 0) begin
        if (model_b.exists(idx)) model_b[idx] = merge(model_b[idx], wdata, be);
        else if (be == 4'hF) model_b[idx] = wdata;
      end else begin
        if (model_a.exists(idx)) begin
          oldw = model_a[idx];
          model_a[idx] = merge(oldw, wdata, be);
        end else if (be == 4'hF) model_a[idx] = wdata;
      end
    end
    n = 0;
    while (o_rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (o_rsp_valid !== 1'b1 || n != lat) begin
      errors++;
      $display("FAIL rsp_latency: got %0d cycles valid=%b want %0d", n, o_rsp_valid, lat);
    end
    checks++;
    if (o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL req_ready_busy: got %b want 0", o_req_ready);
    end
    held_d = o_rsp_rdata; held_e = o_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== held_d || o_rsp_err !== held_e ||
          o_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                 o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready, held_d, held_e);
      end
    end
    t_rsp_ready = 1'b1;
    last_rdata = o_rsp_rdata;
    last_err = o_rsp_err;
    checks++;
    if (o_rsp_err !== exp_err) begin
      errors++;
      $display("FAIL rsp_err: got %b want %b addr=%h", o_rsp_err, exp_err, addr);
    end
    if (known) begin
      checks++;
      if (o_rsp_rdata !== exp_data) begin
        errors++;
        $display("FAIL rsp_rdata: got %h want %h addr=%h", o_rsp_rdata, exp_data, addr);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_rsp: got v=%b rdy=%b want v=0 rdy=1", o_rsp_valid, o_req_ready);
    end
    t_rsp_ready = 1'b0;
    $display("txn dut=%0d we=%0d addr=%h wdata=%h be=%b hold=%0d -> rdata=%h err=%0d",
             s, we, addr, wdata, be, hold, last_rdata, last_err);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      checks++;
      if (o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'd0 ||
          o_rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut=%0d: got rdy=%b v=%b d=%h e=%b want 0 0 0 0",
                 s, o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
      end
    end
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      checks++;
      if (o_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut=%0d: got %b want 1", s, o_req_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    checks++;
    if (last_rdata !== 32'd0 || last_err !== 1'b0) begin
      errors++;
      $display("FAIL store_rsp: got d=%h e=%b want 0 0", last_rdata, last_err);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_back: got %h want deadbeef", last_rdata);
    end
  endtask

  task automatic test_byte_merge();
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_merge: got %h want 11bb33dd", last_rdata);
    end
  endtask

  task automatic test_faults();
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0);
    checks++;
    if (last_err !== 1'b1 || last_rdata !== 32'd0) begin
      errors++;
      $display("FAIL misaligned: got e=%b d=%h want 1 0", last_err, last_rdata);
    end
    txn(0, 1'b1, 32'(4 * DEPTH_A), 32'h12345678, 4'hF, 0);
    checks++;
    if (last_err !== 1'b1) begin
      errors++;
      $display("FAIL out_of_range: got e=%b want 1", last_err);
    end
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL word0_intact: got %h want cafef00d", last_rdata);
    end
  endtask

  task automatic test_backpressure();
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    txn(0, 1'b0, 32'h23, 32'h0, 4'h0, 3);
  endtask

  function automatic logic [31:0] rand_addr(input int depth, input int pool);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = 32'($urandom_range(0, pool - 1) * 4 + $urandom_range(1, 3));
      1: a = 32'((depth + $urandom_range(0, 100)) * 4);
      default: a = 32'($urandom_range(0, pool - 1) * 4);
    endcase
    return a;
  endfunction

  task automatic test_random(input int s, input int pool, input int n);
    int depth;
    depth = (s != 0) ? DEPTH_B : DEPTH_A;
    for (int i = 0; i < pool; i++)
      txn(s, 1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    for (int i = 0; i < n; i++)
      txn(s, 1'($urandom), rand_addr(depth, pool), $urandom, 4'($urandom),
          $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back();
    bit prev_r, prev_v, r, v;
    int accepts;
    txn(1, 1'b1, 32'hC, 32'h0BADF00D, 4'hF, 0);
    sel = 1;
    t_we = 1'b0; t_addr = 32'hC; valid_b = 1'b1; t_rsp_ready = 1'b1;
    prev_r = 1'b0; prev_v = 1'b0; accepts = 0;
    for (int c = 0; c < 10; c++) begin
      r = o_req_ready; v = o_rsp_valid;
      checks++;
      if (r && v) begin
        errors++;
        $display("FAIL b2b_overlap cycle %0d: got rdy=1 v=1 want not both", c);
      end
      if (prev_r) begin
        checks++;
        if (!v || o_rsp_rdata !== 32'h0BADF00D) begin
          errors++;
          $display("FAIL b2b_rsp cycle %0d: got v=%b d=%h want v=1 d=0badf00d",
                   c, v, o_rsp_rdata);
        end
      end
      if (prev_v) begin
        checks++;
        if (!r) begin
          errors++;
          $display("FAIL b2b_ready cycle %0d: got rdy=0 want 1", c);
        end
      end
      if (r) accepts++;
      prev_r = r; prev_v = v;
      @(posedge clk); #1;
    end
    checks++;
    if (accepts != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d acceptances want 5", accepts);
    end
    valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    t_rsp_ready = 1'b0;
    $display("txn dut=1 back-to-back loads addr=0000000c accepts=%0d", accepts);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    t_we = 1'b1; t_addr = 32'h40; t_wdata = 32'h5; t_be = 4'hF; t_rsp_ready = 1'b1;
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    model_a[16] = 32'h5;
    rst_a = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_rst: got %b want 0", o_req_ready);
    end
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'd0 || o_rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_wait_drop cycle %0d: got v=%b d=%h e=%b want 0 0 0",
                 i, o_rsp_valid, o_rsp_rdata, o_rsp_err);
      end
      @(posedge clk); #1;
    end
    $display("txn dut=0 store addr=00000040 wdata=00000005 reset in WAIT");
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'h5) begin
      errors++;
      $display("FAIL post_reset_load: got %h want 00000005", last_rdata);
    end
    // reset while the response is being held off
    t_we = 1'b0; t_addr = 32'h40; t_rsp_ready = 1'b0; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (LAT_A) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_resp_drop cycle %0d: got v=%b want 0", i, o_rsp_valid);
      end
      @(posedge clk); #1;
    end
    $display("txn dut=0 load addr=00000040 reset in RESP");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_faults();
    test_backpressure();
    test_random(0, 32, 60);
    test_random(1, 16, 40);
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/r200_dmem_resp.md
R200_DMEM_RESP -- requirements
Module: r200_dmem_resp

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words of storage (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, wait-state cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  initiator presents a request.
REQ-005 req_ready  output  1  responder accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_be  input  4  store byte enables; bit i enables wdata[8i+7:8i].
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator takes the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access fault for this response.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; exactly one transaction outstanding.
REQ-015 req_ready SHALL be 1 only in IDLE and not in reset; a request is accepted on the edge where req_valid && req_ready.
REQ-016 IDLE -> RESP on acceptance when LATENCY = 0; IDLE -> WAIT on acceptance when LATENCY > 0, loading the wait counter with LATENCY-1.
REQ-017 WAIT decrements the counter each cycle and moves to RESP on the edge where the counter is 0; rsp_valid therefore first asserts in cycle T+1+LATENCY for acceptance edge T.
REQ-018 RESP asserts rsp_valid and moves to IDLE on the edge where rsp_ready = 1; req_ready returns in the following cycle, so there is no same-cycle response and new acceptance.
REQ-019 The block SHALL keep rsp_rdata and rsp_err stable while rsp_valid = 1 and rsp_ready = 0.
REQ-020 Fault conditions: req_addr[1:0] != 0, or req_addr[31:2] >= DEPTH; a fault is decided at acceptance.
REQ-021 A faulting request SHALL not modify storage and SHALL respond with rsp_err = 1 and rsp_rdata = 0 after the normal LATENCY.
REQ-022 A non-faulting store SHALL update storage word req_addr[31:2] on the acceptance edge, per-byte by req_be; req_be = 0000 is a legal no-op.
REQ-023 Store responses SHALL carry rsp_err = 0 and rsp_rdata = 0.
REQ-024 A non-faulting load SHALL latch request fields at acceptance and capture word req_addr[31:2] into rsp_rdata on the edge entering RESP.
REQ-025 Inputs other than rsp_ready are ignored outside IDLE; req_wdata/req_be are ignored for loads.
REQ-026 rsp_valid SHALL be driven 0 in IDLE and WAIT.

Reset
REQ-027 On a clock edge with rst = 1: state IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0; req_ready is 0 during the rst cycle.
REQ-028 Reset mid-transaction (WAIT or RESP) SHALL discard the pending response with no further rsp_valid for it; a store already committed at acceptance remains in storage.
REQ-029 Storage contents SHALL not be cleared by reset.

Verification
REQ-030 LATENCY=2: store addr 0x10, data 0xDEADBEEF, be 1111, accepted at T -> rsp_valid at T+3, rsp_err 0, rsp_rdata 0; then load 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-031 Byte-enable merge: store 0x11223344 to 0x20, then store 0xAABBCCDD with be 0101 -> load 0x20 returns 0x11BB33DD.
REQ-032 Faults: load 0x22 -> rsp_err 1, rsp_rdata 0; store to byte addr 4*DEPTH -> rsp_err 1; later load of word 0 is unchanged.
REQ-033 Backpressure: load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata are held constant and req_ready is 0 throughout; req_ready returns 1 the cycle after rsp_ready = 1.
REQ-034 LATENCY=0: back-to-back loads with rsp_ready = 1 -> rsp_valid at T+1 and the next acceptance no earlier than T+2.
REQ-035 Reset in WAIT after store 0x5 to 0x40 -> no response appears; rsp_valid, rsp_rdata and rsp_err are 0; a post-reset load of 0x40 returns 0x5.
